hazard_sched_ctrl: RTL and testbench
====================================

# hazard_sched_ctrl

Pipeline scheduler for the five-stage core. It produces the execute-stage forwarding selects and the F/D/E stall and flush controls. It sequences multi-cycle multiply/divide operations through the execute stage with a start/done handshake, and keeps saturating stall and flush event counters. It sits beside the execute stage and drives that stage's forwarding muxes, the pipeline-register enables, and the E→M bubble insert.

## Interface
- MDU_MAX_CYCLES, 40: BUSY cycles allowed before timeout.
- CNT_W, 32: width of the performance counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Rs1_D, Rs2_D  in  5  source registers of the instruction in D.
- Rs1_E, Rs2_E, RD_E  in  5  sources and destination of the instruction in E.
- RD_M, RD_W  in  5  destinations in M and W.
- RegWriteM, RegWriteW  in  1  writeback enables in M and W.
- ResultSrcE  in  1  the instruction in E is a load.
- PCSrcE  in  1  taken branch resolved in E.
- MulDivE  in  1  the instruction in E is a multiply/divide.
- mdu_done  in  1  one-cycle pulse from the MDU: result valid.
- clr_cnt  in  1  synchronous clear of the counters.
- ForwardA_E, ForwardB_E  out  2  forwarding selects: 00 register file, 01 ResultW, 10 ALU_ResultM.
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers.
- FlushD, FlushE  out  1  zero IF/ID and ID/EX, inserting a bubble.
- BubbleM  out  1  force RegWriteM and MemWriteM low on the next E→M capture.
- mdu_start  out  1  one-cycle start pulse to the MDU.
- mdu_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- **Forwarding** (combinational), shown for source A; B is identical using Rs2_E.
  - Select 10 if RegWriteM && RD_M≠0 && RD_M==Rs1_E.
  - Otherwise select 01 if RegWriteW && RD_W≠0 && RD_W==Rs1_E.
  - Otherwise select 00.
  - M has priority over W.
- **Load-use hazard:** lu = ResultSrcE && RD_E≠0 && (RD_E==Rs1_D || RD_E==Rs2_D).
- **MDU FSM** with states IDLE, BUSY, DONE.
  - IDLE: if MulDivE, assert mdu_start, StallF, StallD, StallE and BubbleM, and go to BUSY. Otherwise stay in IDLE.
  - BUSY: assert StallF/D/E and BubbleM. Increment the busy counter.
    - mdu_done → DONE.
    - Busy counter reaching MDU_MAX_CYCLES−1 without mdu_done → set mdu_err, go to DONE.
  - DONE: no stalls and no bubble, so the E result is captured into M. mdu_start is suppressed even though MulDivE is still high. Go to IDLE.
- **Control priority**, evaluated each cycle:
  1. In BUSY, or in IDLE with MulDivE: MDU stall only. FlushD, FlushE and load-use handling are suppressed.
  2. PCSrcE: assert FlushD and FlushE, and suppress the load-use stall.
  3. lu: assert StallF, StallD and FlushE.
  4. Otherwise all controls are 0.
- **Counters**
  - stall_cnt increments on every cycle with StallF=1.
  - flush_cnt increments on every cycle with FlushD|FlushE.
  - Both saturate at all-ones. clr_cnt has priority over increment.
- mdu_done received outside BUSY is ignored.

## Timing
- Reset values:
  - FSM state IDLE; busy counter 0; mdu_err 0; stall_cnt and flush_cnt 0.
  - All combinational outputs follow their inputs. With all inputs 0 every output is 0.
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state. They take effect at the next edge.
- Load-use costs 1 bubble. A taken branch costs 2 squashed instructions.
- MDU: if mdu_done arrives k cycles after mdu_start (k≥1), the instruction occupies E for k+2 cycles. There are k+1 stalled cycles, and the result enters M on the DONE edge.
- Reset asserted mid-BUSY aborts to IDLE immediately and clears mdu_err. The MDU must be reset by the same rst.

## Structure
- Shared package `core_pkg`:
  - Forwarding encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - FSM state enum.
  - Register-index width, 5.
- One natural sub-module, `fwd_sel`: pure combinational source-select logic, instantiated once per source. The FSM and counters stay in the top level.

## Test plan
- RD_M=5 with RegWriteM=1, Rs1_E=5; RD_W=5 with RegWriteW=1 → ForwardA_E=10. Drop RegWriteM → 01. RD_M=RD_W=0 → 00.
- Load in E with RD_E=7, Rs2_D=7 → StallF, StallD and FlushE =1 for exactly one cycle; stall_cnt=1.
- Load-use condition plus PCSrcE=1 → FlushD=FlushE=1, StallF=0; flush_cnt=1.
- MulDivE=1 and mdu_done pulsed 3 cycles after mdu_start → one mdu_start pulse, 4 stall cycles with BubbleM, one DONE cycle with no stall, then IDLE. No second start while MulDivE is still high.
- MDU_MAX_CYCLES=4 and mdu_done never asserted → mdu_err=1 after 4 BUSY cycles, pipeline released, err stays high. rst low mid-BUSY → IDLE, err=0.
- Force stall_cnt to all-ones, then stall → value holds. clr_cnt together with a stall → 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the pipeline scheduler: register-index width,
// forwarding select encodings and the MDU sequencing state type.
package core_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_t;

  // A later stage can supply a source only if it writes a non-x0 register that matches.
  function automatic logic dest_hit(input logic             we,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_sched_ctrl_if.sv
// Pipeline-side bundle of the scheduler: register indices and enables in,
// forwarding selects, stall/flush/bubble controls, MDU handshake and counters out.
interface hazard_sched_ctrl_if
  import core_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_W-1:0] Rs1_D;
  logic [REG_W-1:0] Rs2_D;
  logic [REG_W-1:0] Rs1_E;
  logic [REG_W-1:0] Rs2_E;
  logic [REG_W-1:0] RD_E;
  logic [REG_W-1:0] RD_M;
  logic [REG_W-1:0] RD_W;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             ResultSrcE;
  logic             PCSrcE;
  logic             MulDivE;
  logic             mdu_done;
  logic             clr_cnt;

  logic [1:0]       ForwardA_E;
  logic [1:0]       ForwardB_E;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             FlushD;
  logic             FlushE;
  logic             BubbleM;
  logic             mdu_start;
  logic             mdu_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
           RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, mdu_done, clr_cnt,
    input  ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
           BubbleM, mdu_start, mdu_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W,
           RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MulDivE, mdu_done, clr_cnt,
    output ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
           BubbleM, mdu_start, mdu_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_sel.sv
// Execute-stage source select for one operand: M has priority over W,
// register file otherwise.
module fwd_sel
  import core_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic             reg_write_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_w,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_REG;
    if (dest_hit(reg_write_m, rd_m, rs)) begin
      sel = FWD_MEM;
    end else if (dest_hit(reg_write_w, rd_w, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Five-stage pipeline scheduler: forwarding selects, load-use/branch stall and
// flush control, multi-cycle MDU sequencing and saturating event counters.
module hazard_sched_ctrl
  import core_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 40,
  parameter int CNT_W          = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_sched_ctrl_if.slave bus
);

  localparam int BW = (MDU_MAX_CYCLES > 1) ? $clog2(MDU_MAX_CYCLES) : 1;
  localparam logic [BW-1:0] BUSY_LAST = BW'(MDU_MAX_CYCLES - 1);

  mdu_state_t       state_reg, state_next;
  logic [BW-1:0]    busy_cnt_reg, busy_cnt_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

  logic             mdu_hold;
  logic             load_use;
  logic             stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, start;

  logic [REG_W-1:0] rs_e [2];
  logic [1:0]       fwd  [2];

  assign rs_e[0] = bus.Rs1_E;
  assign rs_e[1] = bus.Rs2_E;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel u_fwd_sel (
        .rs          (rs_e[gi]),
        .rd_m        (bus.RD_M),
        .reg_write_m (bus.RegWriteM),
        .rd_w        (bus.RD_W),
        .reg_write_w (bus.RegWriteW),
        .sel         (fwd[gi])
      );
    end
  endgenerate

  assign bus.ForwardA_E = fwd[0];
  assign bus.ForwardB_E = fwd[1];

  assign load_use = bus.ResultSrcE && (bus.RD_E != '0) &&
                    ((bus.RD_E == bus.Rs1_D) || (bus.RD_E == bus.Rs2_D));

  always_comb begin
    state_next    = state_reg;
    busy_cnt_next = busy_cnt_reg;
    err_next      = err_reg;
    start         = 1'b0;
    mdu_hold      = 1'b0;
    stall_f       = 1'b0;
    stall_d       = 1'b0;
    stall_e       = 1'b0;
    flush_d       = 1'b0;
    flush_e       = 1'b0;
    bubble_m      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.MulDivE) begin
          start         = 1'b1;
          mdu_hold      = 1'b1;
          busy_cnt_next = '0;
          state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        mdu_hold = 1'b1;
        if (bus.mdu_done) begin
          busy_cnt_next = '0;
          state_next    = ST_DONE;
        end else if (busy_cnt_reg == BUSY_LAST) begin
          err_next      = 1'b1;
          busy_cnt_next = '0;
          state_next    = ST_DONE;
        end else begin
          busy_cnt_next = busy_cnt_reg + 1'b1;
        end
      end
      // Pipeline released for one cycle so the MDU result moves E->M; MulDivE
      // is still high here, which is why no new start can be issued.
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (mdu_hold) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      bubble_m = 1'b1;
    end else if (bus.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      busy_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      busy_cnt_reg <= busy_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (bus.clr_cnt) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_f && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if ((flush_d || flush_e) && (flush_cnt_reg != {CNT_W{1'b1}})) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.StallE    = stall_e;
  assign bus.FlushD    = flush_d;
  assign bus.FlushE    = flush_e;
  assign bus.BubbleM   = bubble_m;
  assign bus.mdu_start = start;
  assign bus.mdu_err   = err_reg;
  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed bench for hazard_sched_ctrl with a 4-bit counter and a 4-cycle MDU
// timeout so saturation and timeout are reachable in a few cycles.
module tb_hazard_sched_ctrl;
  import core_pkg::*;

  localparam int CW = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_sched_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_sched_ctrl #(
    .MDU_MAX_CYCLES (4),
    .CNT_W          (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus.Rs1_D = '0; bus.Rs2_D = '0; bus.Rs1_E = '0; bus.Rs2_E = '0;
    bus.RD_E = '0; bus.RD_M = '0; bus.RD_W = '0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.ResultSrcE = 1'b0;
    bus.PCSrcE = 1'b0; bus.MulDivE = 1'b0; bus.mdu_done = 1'b0; bus.clr_cnt = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    zero_inputs();
    #3;
    chk("rst_fwdA", 32'(bus.ForwardA_E), 32'd0);
    chk("rst_fwdB", 32'(bus.ForwardB_E), 32'd0);
    chk("rst_stallF", 32'(bus.StallF), 32'd0);
    chk("rst_flushE", 32'(bus.FlushE), 32'd0);
    chk("rst_start", 32'(bus.mdu_start), 32'd0);
    chk("rst_err", 32'(bus.mdu_err), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    #9 rst = 1'b1;
    step();

    // Forwarding priority
    bus.RegWriteM = 1'b1; bus.RD_M = 5'd5; bus.Rs1_E = 5'd5;
    bus.RegWriteW = 1'b1; bus.RD_W = 5'd5; bus.Rs2_E = 5'd5;
    #1;
    chk("fwdA_mem_prio", 32'(bus.ForwardA_E), 32'(FWD_MEM));
    chk("fwdB_mem_prio", 32'(bus.ForwardB_E), 32'(FWD_MEM));
    bus.RegWriteM = 1'b0;
    #1;
    chk("fwdA_wb", 32'(bus.ForwardA_E), 32'(FWD_WB));
    bus.RegWriteM = 1'b1; bus.RD_M = 5'd0; bus.RD_W = 5'd0;
    #1;
    chk("fwdA_x0", 32'(bus.ForwardA_E), 32'(FWD_REG));
    bus.RD_M = 5'd9; bus.RD_W = 5'd6; bus.Rs2_E = 5'd6; bus.Rs1_E = 5'd9;
    #1;
    chk("fwdB_wb_split", 32'(bus.ForwardB_E), 32'(FWD_WB));
    chk("fwdA_mem_split", 32'(bus.ForwardA_E), 32'(FWD_MEM));
    zero_inputs();

    // Load-use: one bubble
    bus.ResultSrcE = 1'b1; bus.RD_E = 5'd7; bus.Rs2_D = 5'd7;
    #1;
    chk("lu_stallF", 32'(bus.StallF), 32'd1);
    chk("lu_stallD", 32'(bus.StallD), 32'd1);
    chk("lu_flushE", 32'(bus.FlushE), 32'd1);
    chk("lu_stallE", 32'(bus.StallE), 32'd0);
    chk("lu_flushD", 32'(bus.FlushD), 32'd0);
    step();
    zero_inputs();
    #1;
    chk("lu_released", 32'(bus.StallF), 32'd0);
    chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    chk("lu_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    chk("clr_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("clr_flush_cnt", 32'(bus.flush_cnt), 32'd0);

    // Branch overrides load-use
    bus.ResultSrcE = 1'b1; bus.RD_E = 5'd7; bus.Rs2_D = 5'd7; bus.PCSrcE = 1'b1;
    #1;
    chk("br_flushD", 32'(bus.FlushD), 32'd1);
    chk("br_flushE", 32'(bus.FlushE), 32'd1);
    chk("br_stallF", 32'(bus.StallF), 32'd0);
    step();
    zero_inputs();
    #1;
    chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // MDU with done 3 cycles after start
    bus.MulDivE = 1'b1;
    #1;
    chk("mdu_c0_start", 32'(bus.mdu_start), 32'd1);
    chk("mdu_c0_stallE", 32'(bus.StallE), 32'd1);
    chk("mdu_c0_bubble", 32'(bus.BubbleM), 32'd1);
    bus.PCSrcE = 1'b1;
    #1;
    chk("mdu_c0_noflush", 32'(bus.FlushD), 32'd0);
    bus.PCSrcE = 1'b0;
    step();
    chk("mdu_c1_start", 32'(bus.mdu_start), 32'd0);
    chk("mdu_c1_stallF", 32'(bus.StallF), 32'd1);
    step();
    chk("mdu_c2_bubble", 32'(bus.BubbleM), 32'd1);
    step();
    bus.mdu_done = 1'b1;
    #1;
    chk("mdu_c3_stallD", 32'(bus.StallD), 32'd1);
    step();
    bus.mdu_done = 1'b0;
    #1;
    chk("mdu_done_stallF", 32'(bus.StallF), 32'd0);
    chk("mdu_done_bubble", 32'(bus.BubbleM), 32'd0);
    chk("mdu_done_nostart", 32'(bus.mdu_start), 32'd0);
    step();
    bus.MulDivE = 1'b0;
    #1;
    chk("mdu_idle_stallF", 32'(bus.StallF), 32'd0);
    chk("mdu_stall_cnt", 32'(bus.stall_cnt), 32'd4);
    chk("mdu_err_clean", 32'(bus.mdu_err), 32'd0);
    bus.mdu_done = 1'b1;
    step();
    bus.mdu_done = 1'b0;
    #1;
    chk("stray_done_idle", 32'(bus.StallF), 32'd0);

    // Timeout after 4 BUSY cycles
    bus.MulDivE = 1'b1;
    #1;
    chk("to_start", 32'(bus.mdu_start), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_busy_stall", 32'(bus.StallF), 32'd1);
    end
    chk("to_err_pre", 32'(bus.mdu_err), 32'd0);
    step();
    chk("to_err_set", 32'(bus.mdu_err), 32'd1);
    chk("to_released", 32'(bus.StallF), 32'd0);
    chk("to_stall_cnt", 32'(bus.stall_cnt), 32'd9);
    bus.MulDivE = 1'b0;
    step();
    chk("to_err_sticky", 32'(bus.mdu_err), 32'd1);

    // Reset mid-BUSY
    bus.MulDivE = 1'b1;
    step();
    bus.MulDivE = 1'b0;
    step();
    chk("busy_stallF", 32'(bus.StallF), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_stallF", 32'(bus.StallF), 32'd0);
    chk("midrst_err", 32'(bus.mdu_err), 32'd0);
    #2 rst = 1'b1;
    step();
    chk("postrst_stallF", 32'(bus.StallF), 32'd0);

    // Saturation and clear-over-increment
    bus.ResultSrcE = 1'b1; bus.RD_E = 5'd7; bus.Rs1_D = 5'd7;
    for (int i = 0; i < 17; i++) step();
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'd15);
    chk("sat_flush_cnt", 32'(bus.flush_cnt), 32'd15);
    bus.clr_cnt = 1'b1;
    step();
    bus.clr_cnt = 1'b0;
    chk("clr_prio_stall", 32'(bus.stall_cnt), 32'd0);
    chk("clr_prio_flush", 32'(bus.flush_cnt), 32'd0);
    zero_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
